// File: rtl/act_vector_serializer.sv
// act_vector_serializer
// Takes one parallel activation vector (LENGTH elements) from the activation
// stage and streams it out one element per beat, each element tagged with its
// write address in the unified activation buffer.
//
// Handshake rules, both sides: a transfer happens on a rising edge where
// valid && ready are both high. A producer holds valid and its payload stable
// until the transfer. Valid never depends combinationally on ready. The only
// combinational path in this block is from out_ready to in_ready. That path
// lets a new vector be captured on the same edge as the last beat of the
// current one.

module act_vector_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0]    In,
    input  logic [ADDR_WIDTH-1:0]                base_addr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [ADDR_WIDTH-1:0]                out_addr,
    output logic                                 out_last,
    output logic                                 busy
);

    localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Held vector, its base address, and the element currently presented.
    logic [LENGTH-1:0][DATA_WIDTH-1:0] vbuf;
    logic [ADDR_WIDTH-1:0]             base;
    logic [IDX_W-1:0]                  idx;

    // Datapath controls decoded by the FSM.
    logic at_last;
    logic load;
    logic advance;
    logic finish;

    assign at_last = (idx == LAST_IDX);

    // State register; reset always wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (at_last) begin
                        // Last beat leaves: a waiting vector is taken on the
                        // same edge so the stream has no bubble.
                        in_ready = 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            finish     = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Vector capture and element index stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            vbuf <= '0;
            base <= '0;
            idx  <= '0;
        end else if (load) begin
            vbuf <= In;
            base <= base_addr;
            idx  <= '0;
        end else if (advance) begin
            idx <= idx + 1'b1;
        end else if (finish) begin
            idx <= '0;
        end
    end

    // Output beat: derived only from registered state. In IDLE the beat
    // fields read as zero so an idle bus is quiet.
    assign busy      = (state == SEND);
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && at_last;
    assign out_data  = (state == SEND) ? vbuf[idx] : '0;
    assign out_addr  = (state == SEND) ? (base + ADDR_WIDTH'(idx)) : '0;

endmodule

// File: tb/tb_act_vector_serializer.sv
// Bench for act_vector_serializer: directed scenarios plus a randomized run.
// Expected beats come from a queue filled when a vector is handed over; a
// monitor checks every cycle's outputs against that queue.

module tb_act_vector_serializer;

    localparam int DW = 16;
    localparam int L  = 16;
    localparam int AW = 8;
    localparam int W  = DW + AW + 1;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [L-1:0][DW-1:0]    In;
    logic [AW-1:0]           base_addr;
    logic                    out_valid;
    logic                    out_ready;
    logic [DW-1:0]           out_data;
    logic [AW-1:0]           out_addr;
    logic                    out_last;
    logic                    busy;

    // Scoreboard state.
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int beats = 0;
    bit chk_zero = 0;

    // out_ready drive: 0 = always 1, 1 = pattern 1,0,0, 2 = random, 3 = ordy_val.
    int ordy_mode = 0;
    bit ordy_val  = 1;
    int ordy_cnt  = 0;
    bit b_done    = 0;

    act_vector_serializer #(
        .DATA_WIDTH(DW),
        .LENGTH(L),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .In(In),
        .base_addr(base_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_addr(out_addr),
        .out_last(out_last),
        .busy(busy)
    );

    // Clock and watchdog.
    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // out_ready driver.
    always @(negedge clk) begin
        case (ordy_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (ordy_cnt == 0);
                ordy_cnt  = (ordy_cnt == 2) ? 0 : ordy_cnt + 1;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = ordy_val;
        endcase
    end

    // Monitor: compares the cycle's outputs with the model just before the edge.
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            logic exp_v;
            logic exp_r;
            exp_v = (exp_q.size() != 0);
            exp_r = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            check("out_valid", 32'(out_valid), 32'(exp_v));
            check("busy", 32'(busy), 32'(exp_v));
            check("in_ready", 32'(in_ready), 32'(exp_r));
            if (chk_zero) begin
                check("zero_data", 32'(out_data), 32'd0);
                check("zero_addr", 32'(out_addr), 32'd0);
                check("zero_last", 32'(out_last), 32'd0);
                chk_zero = 0;
            end
            if (exp_v && out_valid) begin
                check("beat", 32'({out_data, out_addr, out_last}), 32'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    // Offer a vector until accepted; push its expected beats on acceptance.
    task automatic push_vec(input logic [L-1:0][DW-1:0] v, input logic [AW-1:0] b);
        int waited = 0;
        bit acc = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        In        = v;
        base_addr = b;
        while (!acc) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                for (int i = 0; i < L; i++) begin
                    logic [AW-1:0] a;
                    logic lst;
                    a   = b + AW'(i);
                    lst = (i == L - 1);
                    exp_q.push_back({v[i], a, lst});
                end
            end else begin
                waited++;
                if (waited > 200) begin
                    total++;
                    bad++;
                    $display("FAIL accept got=no_accept exp=accept");
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int c = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic do_reset(input bit with_iv);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = with_iv;
        In        = rand_vec();
        base_addr = AW'($urandom_range(0, 255));
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_zero = 1;
    endtask

    function automatic logic [L-1:0][DW-1:0] rand_vec();
        logic [L-1:0][DW-1:0] v;
        for (int i = 0; i < L; i++) v[i] = DW'($urandom);
        return v;
    endfunction

    function automatic logic [L-1:0][DW-1:0] ramp_vec(input int start);
        logic [L-1:0][DW-1:0] v;
        for (int i = 0; i < L; i++) v[i] = DW'(start + i);
        return v;
    endfunction

    initial begin
        logic [L-1:0][DW-1:0] va;
        logic [L-1:0][DW-1:0] vb;
        int beats0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        In        = '0;
        base_addr = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        chk_zero = 1;
        idle(2);

        // Single vector, ramp data from 0x100 at base 0x20.
        ordy_mode = 0;
        push_vec(ramp_vec(16'h100), 8'h20);
        drain();
        idle(2);

        // Backpressure 1,0,0 pattern.
        beats0    = beats;
        ordy_mode = 1;
        push_vec(ramp_vec(16'h200), 8'h10);
        drain();
        check("bp_transfers", 32'(beats - beats0), 32'(L));
        ordy_mode = 0;
        idle(2);

        // Back-to-back A then B with in_valid held.
        beats0 = beats;
        push_vec(ramp_vec(16'hA00), 8'h00);
        push_vec(ramp_vec(16'hB00), 8'h40);
        drain();
        check("b2b_transfers", 32'(beats - beats0), 32'(2 * L));
        idle(2);

        // Address wrap from base 250.
        push_vec(rand_vec(), 8'd250);
        drain();
        idle(2);

        // Reset while element 5 is presented, with in_valid also high.
        push_vec(rand_vec(), 8'h80);
        idle(5);
        do_reset(1'b1);
        push_vec(ramp_vec(16'h300), 8'h05);
        drain();
        idle(2);

        // New vector waiting while the last beat is stalled.
        ordy_mode = 3;
        ordy_val  = 1;
        va = rand_vec();
        vb = rand_vec();
        push_vec(va, 8'h60);
        idle(8);
        b_done = 0;
        fork
            begin
                push_vec(vb, 8'h90);
                b_done = 1;
            end
        join_none
        repeat (7) @(negedge clk);
        @(posedge clk);
        ordy_val = 0;
        repeat (4) @(posedge clk);
        ordy_val = 1;
        for (int c = 0; c < 100 && !b_done; c++) @(posedge clk);
        check("stall_b_accepted", 32'(b_done), 32'd1);
        drain();
        ordy_mode = 0;
        idle(2);

        // Randomized vectors, random backpressure and gaps.
        ordy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            push_vec(rand_vec(), AW'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end
        drain();
        ordy_mode = 0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_vector_serializer.md
# act_vector_serializer

Drains one ReLU output vector (LENGTH elements of DATA_WIDTH bits, presented in parallel) into a stream of single elements with write addresses, for storage in the unified activation buffer. It sits directly downstream of the activation stage: it is the reader side of the parallel activation-vector interface. It uses valid/ready handshakes on both sides and accepts back-to-back vectors with no bubble cycles.

## Interface
- DATA_WIDTH, 16, bits per element
- LENGTH, 16, elements per vector (LENGTH >= 2)
- ADDR_WIDTH, 8, buffer address width
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  vector on In/base_addr is valid
- in_ready  output  1  block can accept a vector this cycle
- In  input  [LENGTH-1:0][DATA_WIDTH-1:0]  activation vector, element i = In[i]
- base_addr  input  ADDR_WIDTH  buffer address of element 0
- out_valid  output  1  out_data/out_addr/out_last are valid
- out_ready  input  1  downstream accepts the element this cycle
- out_data  output  DATA_WIDTH  current element
- out_addr  output  ADDR_WIDTH  write address of current element
- out_last  output  1  current element is In[LENGTH-1]
- busy  output  1  a vector is held (state SEND)

## Operation
- Storage: vector register vbuf (LENGTH x DATA_WIDTH), base register, index counter idx ($clog2(LENGTH) bits).
- States: IDLE, SEND.
- IDLE: in_ready=1, out_valid=0. If in_valid: capture In into vbuf, base_addr into base, idx<=0, go to SEND.
- SEND: out_valid=1; out_data=vbuf[idx]; out_addr=(base+idx) mod 2^ADDR_WIDTH; out_last=(idx==LENGTH-1).
- Beat transfer = out_valid && out_ready. With no transfer, all outputs hold stable.
- Transfer with idx<LENGTH-1: idx<=idx+1.
- Transfer with idx==LENGTH-1:
  - if in_valid, capture the new vector and base, set idx<=0, and stay in SEND;
  - otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==SEND && idx==LENGTH-1 && out_ready). This is a combinational path from out_ready to in_ready only. in_valid must not depend combinationally on in_ready.
- While in_ready=0, In/base_addr are ignored. The upstream holds the vector.
- Address arithmetic: ADDR_WIDTH-bit unsigned add, which wraps silently (base=2^ADDR_WIDTH-1, idx=1 gives address 0).
- Data is passed unmodified; there is no sign handling or saturation.
- busy = (state==SEND).

## Timing
- Reset values: state=IDLE, idx=0, vbuf=0, base=0. This gives out_valid=0, out_last=0, out_data=0, out_addr=0, busy=0, in_ready=1 in the first cycle after reset.
- Reset takes priority over every handshake in the same cycle. Reset mid-vector drops the remaining elements. out_valid is 0 in the next cycle.
- Latency: a vector accepted at edge N presents element 0 from edge N onward (visible in cycle N+1).
- Throughput: with out_ready held high and in_valid continuous, one element per cycle, LENGTH cycles per vector, zero idle cycles between vectors.
- out_valid never deasserts without a transfer except on reset.
- All outputs except in_ready are purely registered-state derived.

## Test plan
- Single vector, LENGTH=16, In[i]=i+0x100, base_addr=0x20, out_ready=1:
  - in_ready low for 15 cycles, then high again while the last beat is presented (returning to IDLE);
  - beats 0x100..0x10F at addresses 0x20..0x2F;
  - out_last only on the 16th beat;
  - busy falls after it.
- Backpressure: out_ready toggles 1,0,0,1,... -> no element lost or duplicated, outputs stable during stalls, 16 transfers total in order.
- Back-to-back: two vectors (A at base 0x00, B at base 0x40), in_valid held high, out_ready=1:
  - 32 consecutive beats, A then B with no gap;
  - B accepted on A's last beat;
  - out_last high at beats 16 and 32.
- Address wrap: ADDR_WIDTH=8, base_addr=250 -> addresses 250..255 then 0..9.
- Reset at beat 5 of a vector, with in_valid also asserted that cycle:
  - next cycle out_valid=0, busy=0, in_ready=1, outputs zero;
  - a new vector then starts at its own element 0.
- in_valid asserted mid-vector with out_ready=0 on the last beat -> in_ready stays 0, new vector not captured until the last beat transfers.
